register_file_tri: RTL and testbench
====================================

# register_file_tri

Parametrised bank of DEPTH general-purpose registers, each WIDTH bits, with one synchronous write port and two independently tri-stated read ports. It is the next generation of the single 32-bit enable/tri-state bus register. Several architectural registers share one write path from the data bus, and each read port can drive a shared tri-state bus or float. Per-register valid flags tell the controller which registers have been written since reset or clear.

## Interface
Parameters:
- WIDTH, 32, data width of every register and port (≥1)
- DEPTH, 8, number of registers (≥2, need not be a power of two)
- AW, $clog2(DEPTH), derived select width; not overridden by instantiators

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in  in  WIDTH  write data
- wsel  in  AW  write/clear register select
- we  in  1  write enable
- clr  in  1  clear enable for register wsel (priority over we)
- rsel_a  in  AW  read port A register select
- oe_a  in  1  port A output enable
- out_a  out  WIDTH  port A data; high impedance when oe_a=0
- rsel_b  in  AW  read port B register select
- oe_b  in  1  port B output enable
- out_b  out  WIDTH  port B data; high impedance when oe_b=0
- valid  out  DEPTH  bit i=1 when register i holds written data
- err  out  1  registered flag: previous cycle's write or clear targeted an out-of-range wsel

## Operation
- Reset (rst=1 at rising edge): all registers ← 0, valid ← 0, err ← 0. rst overrides we and clr in the same cycle.
- Clear: clr=1 and wsel<DEPTH: reg[wsel] ← 0, valid[wsel] ← 0. we is ignored that cycle.
- Write: we=1, clr=0, wsel<DEPTH: reg[wsel] ← in, valid[wsel] ← 1.
- Out-of-range: (we|clr)=1 and wsel≥DEPTH: no register changes; err ← 1 for one cycle. Otherwise err ← 0 each cycle.
- Read: out_x = oe_x ? reg[rsel_x] : all-Z. Reads are combinational from the register array.
  - rsel_x≥DEPTH with oe_x=1 drives all zeros.
  - Both ports may select the same register simultaneously.
- oe_a and oe_b are not gated by rst. The outputs float or drive during reset purely per oe. During reset they show the current array contents, which are zero from the following cycle onward.
- A register that has not been written reads 0. The valid flag, not the data value, distinguishes it from a written zero.

## Timing
- Write latency: data written at edge N is visible on a read port after edge N (same cycle as the edge, combinational read). This holds without bypass.
- Same-cycle write and read of the same register: the read port shows the old value before the edge, unless bypass is compiled in (see Configuration).
- Output enable: combinational, zero cycle latency; Z↔driven follows oe_x within the same cycle.
- valid and err are registered and change only on rising edges.
- rst asserted mid-operation discards any write or clear presented in that cycle.

## Configuration
- REGISTER_FILE_TRI_BYPASS_EN defined:
  - When we=1, clr=0, wsel<DEPTH and rsel_x==wsel, out_x (if oe_x=1) drives `in` combinationally in that cycle (write-through forwarding).
  - When clr=1 targets rsel_x, out_x drives 0.
  - rst=1 disables forwarding.
- Not defined: no forwarding. Reads always return pre-edge register contents.
- Registered state, valid and err are identical in both builds.

## Test plan
- Reset: rst=1 one cycle, oe_a=oe_b=1 → out_a=out_b=0, valid=0, err=0. Then oe_a=0 → out_a all-Z.
- Write/read: write 0xDEADBEEF to reg 3 and 0x12345678 to reg 5 on consecutive cycles. Then rsel_a=3, rsel_b=5 → out_a=0xDEADBEEF, out_b=0x12345678, valid=8'b0010_1000.
- Clear priority: we=1, clr=1, wsel=3, in=0xFFFFFFFF → reg 3 reads 0, valid[3]=0. Reg 5 unchanged.
- Out-of-range (DEPTH=6): we=1, wsel=7 → no register changes, err=1 for exactly one cycle. rsel_a=7, oe_a=1 → out_a=0.
- Same-cycle hazard: reg 2=0xA, we=1, wsel=2, in=0xB, rsel_a=2.
  - Bypass off → out_a=0xA before the edge, 0xB after.
  - Bypass on → out_a=0xB before the edge.
- Reset mid-write: rst=1 with we=1, wsel=1, in=0x55 → reg 1 reads 0 and valid[1]=0 after the edge.

Source files
------------

// File: rtl/register_file_tri.sv
// register_file_tri: DEPTH x WIDTH register bank with one synchronous write
// port and two tri-stated combinational read ports. Per-register valid flags
// mark registers written since reset or since they were last cleared.
// Optional build macro: REGISTER_FILE_TRI_BYPASS_EN. When it is defined, a
// write or clear presented this cycle is forwarded to any read port that
// selects the same register.
module register_file_tri #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic [AW-1:0]     wsel,
  input  logic              we,
  input  logic              clr,
  input  logic [AW-1:0]     rsel_a,
  input  logic              oe_a,
  output tri logic [WIDTH-1:0] out_a,
  input  logic [AW-1:0]     rsel_b,
  input  logic              oe_b,
  output tri logic [WIDTH-1:0] out_b,
  output logic [DEPTH-1:0]  valid,
  output logic              err
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wsel_ok;
  logic             rsel_a_ok;
  logic             rsel_b_ok;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // DEPTH need not be a power of two, so selects can point past the array.
  assign wsel_ok   = (32'(wsel)   < 32'(DEPTH));
  assign rsel_a_ok = (32'(rsel_a) < 32'(DEPTH));
  assign rsel_b_ok = (32'(rsel_b) < 32'(DEPTH));

  // Register array, valid flags and error flag; clear wins over write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      valid <= '0;
      err   <= 1'b0;
    end else begin
      err <= (we | clr) & ~wsel_ok;
      if (wsel_ok) begin
        if (clr) begin
          regs[wsel]  <= '0;
          valid[wsel] <= 1'b0;
        end else if (we) begin
          regs[wsel]  <= in;
          valid[wsel] <= 1'b1;
        end
      end
    end
  end

  // Port A read mux; out-of-range selects read as zero.
  always_comb begin
    rd_a = '0;
    if (rsel_a_ok) begin
      rd_a = regs[rsel_a];
`ifdef REGISTER_FILE_TRI_BYPASS_EN
      if (!rst && (rsel_a == wsel)) begin
        if (clr) begin
          rd_a = '0;
        end else if (we) begin
          rd_a = in;
        end
      end
`endif
    end
  end

  // Port B read mux; out-of-range selects read as zero.
  always_comb begin
    rd_b = '0;
    if (rsel_b_ok) begin
      rd_b = regs[rsel_b];
`ifdef REGISTER_FILE_TRI_BYPASS_EN
      if (!rst && (rsel_b == wsel)) begin
        if (clr) begin
          rd_b = '0;
        end else if (we) begin
          rd_b = in;
        end
      end
`endif
    end
  end

  // Output enables are deliberately not gated by rst.
  assign out_a = oe_a ? rd_a : {WIDTH{1'bz}};
  assign out_b = oe_b ? rd_b : {WIDTH{1'bz}};

endmodule

// File: tb/tb_register_file_tri.sv
// Bench for register_file_tri (DEPTH=6 so out-of-range selects are reachable).
// Output nets are pulled up, so a floating port reads as all ones.
module tb_register_file_tri;
  localparam int W  = 32;
  localparam int D  = 6;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in;
  logic [AW-1:0] wsel;
  logic          we;
  logic          clr;
  logic [AW-1:0] rsel_a;
  logic          oe_a;
  logic [AW-1:0] rsel_b;
  logic          oe_b;
  tri1  [W-1:0]  out_a;
  tri1  [W-1:0]  out_b;
  logic [D-1:0]  valid;
  logic          err;

  register_file_tri #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in(in), .wsel(wsel), .we(we), .clr(clr),
    .rsel_a(rsel_a), .oe_a(oe_a), .out_a(out_a),
    .rsel_b(rsel_b), .oe_b(oe_b), .out_b(out_b),
    .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  // Reference state: plain arrays updated from the operation rules.
  logic [W-1:0] m_regs [D];
  logic [D-1:0] m_valid = '0;
  logic         m_err = 1'b0;

  initial begin
    for (int i = 0; i < D; i++) m_regs[i] = '0;
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_out(input logic [AW-1:0] rs, input logic o);
    if (!o) return '1;
    if (int'(rs) >= D) return '0;
`ifdef REGISTER_FILE_TRI_BYPASS_EN
    if (!rst && rs == wsel) begin
      if (clr) return '0;
      if (we) return in;
    end
`endif
    return m_regs[rs];
  endfunction

  // Model update on each rising edge using the inputs held during the cycle.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) m_regs[i] = '0;
      m_valid = '0;
      m_err   = 1'b0;
    end else begin
      m_err = (we || clr) && (int'(wsel) >= D);
      if (int'(wsel) < D) begin
        if (clr) begin
          m_regs[wsel]  = '0;
          m_valid[wsel] = 1'b0;
        end else if (we) begin
          m_regs[wsel]  = in;
          m_valid[wsel] = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison at the falling edge, once reset has been applied.
  always @(negedge clk) begin
    if (checking) begin
      check("cyc_out_a", out_a, exp_out(rsel_a, oe_a));
      check("cyc_out_b", out_b, exp_out(rsel_b, oe_b));
      check("cyc_valid", W'(valid), W'(m_valid));
      check("cyc_err",   W'(err),   W'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [W-1:0] hz_exp;

  initial begin
    rst = 1'b1; in = '0; wsel = '0; we = 1'b0; clr = 1'b0;
    rsel_a = '0; oe_a = 1'b1; rsel_b = '0; oe_b = 1'b1;
    cyc();
    checking = 1'b1;
    rst = 1'b0;
    #1;
    check("rst_out_a", out_a, 32'h0);
    check("rst_out_b", out_b, 32'h0);
    check("rst_valid", W'(valid), 32'h0);
    check("rst_err",   W'(err), 32'h0);
    oe_a = 1'b0;
    #1;
    check("float_out_a", out_a, 32'hFFFF_FFFF);
    oe_a = 1'b1;

    // Two writes, then read both back.
    we = 1'b1; wsel = 3'd3; in = 32'hDEAD_BEEF;
    cyc();
    wsel = 3'd5; in = 32'h1234_5678;
    cyc();
    we = 1'b0; rsel_a = 3'd3; rsel_b = 3'd5;
    #1;
    check("wr_out_a", out_a, 32'hDEAD_BEEF);
    check("wr_out_b", out_b, 32'h1234_5678);
    check("wr_valid", W'(valid), 32'b10_1000);

    // Clear beats write.
    we = 1'b1; clr = 1'b1; wsel = 3'd3; in = 32'hFFFF_FFFF;
    cyc();
    we = 1'b0; clr = 1'b0;
    #1;
    check("clr_out_a", out_a, 32'h0);
    check("clr_valid", W'(valid), 32'b10_0000);
    check("clr_out_b", out_b, 32'h1234_5678);

    // Out-of-range write: one-cycle err, nothing changes.
    we = 1'b1; wsel = 3'd7; in = 32'hCAFE_F00D;
    cyc();
    we = 1'b0;
    #1;
    check("oor_err_hi", W'(err), 32'h1);
    check("oor_valid",  W'(valid), 32'b10_0000);
    cyc();
    #1;
    check("oor_err_lo", W'(err), 32'h0);
    rsel_a = 3'd7;
    #1;
    check("oor_read", out_a, 32'h0);

    // Same-cycle write/read hazard on reg 2.
    we = 1'b1; wsel = 3'd2; in = 32'hA;
    cyc();
    in = 32'hB; rsel_a = 3'd2;
    #1;
`ifdef REGISTER_FILE_TRI_BYPASS_EN
    hz_exp = 32'hB;
`else
    hz_exp = 32'hA;
`endif
    check("hz_pre", out_a, hz_exp);
    cyc();
    we = 1'b0;
    #1;
    check("hz_post", out_a, 32'hB);

    // Reset discards a simultaneous write.
    rst = 1'b1; we = 1'b1; wsel = 3'd1; in = 32'h55;
    cyc();
    rst = 1'b0; we = 1'b0; rsel_a = 3'd1;
    #1;
    check("rstwr_out_a", out_a, 32'h0);
    check("rstwr_valid", W'(valid), 32'h0);

    // Randomized traffic checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 63) == 0);
      we     = ($urandom_range(0, 2) != 0);
      clr    = ($urandom_range(0, 7) == 0);
      wsel   = AW'($urandom_range(0, 7));
      in     = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      rsel_a = ($urandom_range(0, 3) == 0) ? wsel : AW'($urandom_range(0, 7));
      rsel_b = ($urandom_range(0, 3) == 0) ? wsel : AW'($urandom_range(0, 7));
      oe_a   = ($urandom_range(0, 4) != 0);
      oe_b   = ($urandom_range(0, 4) != 0);
      cyc();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
